mo_line_buffer: RTL and testbench

//  Motion-object (sprite) line engine fed by the working RAM's 16-bit video-phase SR read port.
//  - During scan it samples object descriptors as HC advances.
//  - Hit-tests each descriptor against the next scanline and fetches the 8-pixel row from picture ROM (req/ack).
//  - Paints that row into a double line buffer; the video mixer reads the other half during display.

---
 rtl/mo_pkg.sv | 20 ++
 rtl/mo_line_buffer_if.sv | 23 ++
 rtl/mo_linebuf_dp.sv | 50 +++++
 rtl/mo_line_buffer.sv | 176 +++++++++++++++++
 tb/tb_mo_line_buffer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mo_pkg.sv
// Shared types and constants for the motion-object line engine.
package mo_pkg;

    localparam int unsigned ATTR_HFLIP_BIT = 4;
    localparam logic [3:0]  TRANSPARENT    = 4'h0;

    typedef struct packed {
        logic [7:0] picture;
        logic [3:0] row;
        logic [4:0] attr;
        logic [7:0] hpos;
    } mo_desc_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDraw
    } mo_state_e;

endpackage

// File: rtl/mo_line_buffer_if.sv
// Picture ROM fetch bus: request/address out, one-cycle ack with data back.
interface mo_line_buffer_if;

    logic        rom_req;
    logic [11:0] rom_addr;
    logic        rom_ack;
    logic [31:0] rom_data;

    modport master (
        output rom_req,
        output rom_addr,
        input  rom_ack,
        input  rom_data
    );

    modport slave (
        input  rom_req,
        input  rom_addr,
        output rom_ack,
        output rom_data
    );

endinterface

// File: rtl/mo_linebuf_dp.sv
// Double 256x8 line buffer: build half takes pixel writes, display half is read then cleared.
module mo_linebuf_dp (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sel,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] ram_a [256];
    logic [7:0] ram_b [256];
    logic [7:0] rd_data_q;
    logic [7:0] clr_addr_q;
    logic       clr_b_q;
    logic       clr_vld_q;

    // sel=1: build into A, display from B. The clear remembers which half it read.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_q  <= 8'h00;
            clr_addr_q <= 8'h00;
            clr_b_q    <= 1'b0;
            clr_vld_q  <= 1'b0;
        end else begin
            rd_data_q  <= sel ? ram_b[rd_addr] : ram_a[rd_addr];
            clr_addr_q <= rd_addr;
            clr_b_q    <= sel;
            clr_vld_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && sel) begin
            ram_a[wr_addr] <= wr_data;
        end else if (clr_vld_q && !clr_b_q) begin
            ram_a[clr_addr_q] <= 8'h00;
        end
        if (wr_en && !sel) begin
            ram_b[wr_addr] <= wr_data;
        end else if (clr_vld_q && clr_b_q) begin
            ram_b[clr_addr_q] <= 8'h00;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/mo_line_buffer.sv
// Motion-object line engine: samples descriptors, hit-tests, fetches rows and paints a line buffer.
module mo_line_buffer
    import mo_pkg::*;
#(
    parameter int unsigned NUM_OBJ = 40,
    parameter int unsigned OBJ_H   = 16,
    parameter int unsigned FIFO_D  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ce2H,
    input  logic [8:0]              HC,
    input  logic [7:0]              VNEXT,
    input  logic                    BUF1BUF2n,
    input  logic [15:0]             SR,
    mo_line_buffer_if.master        rom,
    input  logic [7:0]              disp_x,
    output logic [7:0]              disp_pix,
    output logic                    mo_ovf
);

    localparam int unsigned PtrW = $clog2(FIFO_D);

    logic            buf_q;
    logic            line_chg;
    logic [6:0]      word_idx;
    logic            sample;
    logic            hit;
    logic [7:0]      picture_q;
    logic [7:0]      vpos_q;
    logic [7:0]      row;
    mo_desc_t        push_desc;
    mo_desc_t        fifo_q [FIFO_D];
    mo_desc_t        head;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            full;
    logic            push;
    logic            pop;
    logic            ovf_q;
    mo_state_e       state_q;
    mo_state_e       state_d;
    logic [11:0]     addr_q;
    logic [4:0]      cur_attr_q;
    logic [7:0]      cur_hpos_q;
    logic [31:0]     data_q;
    logic [2:0]      pix_cnt_q;
    logic [2:0]      pix_sel;
    logic [3:0]      draw_pix;
    logic            wr_en;
    logic [7:0]      wr_addr;
    logic [7:0]      wr_data;

    // Any edge of the buffer select is a line change seen on the following clock.
    assign line_chg = BUF1BUF2n ^ buf_q;
    assign word_idx = HC[8:2];
    assign sample   = ce2H && (HC[1:0] == 2'b11) && (32'(word_idx) < 2 * NUM_OBJ);
    assign row      = VNEXT - vpos_q;
    assign hit      = sample && HC[2] && (32'(row) < OBJ_H);
    assign push_desc = '{picture: picture_q, row: row[3:0], attr: SR[12:8], hpos: SR[7:0]};

    // Power-of-two depth: the count MSB alone marks full.
    assign full = count_q[PtrW];
    assign push = hit && !full && !line_chg;
    assign head = fifo_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buf_q     <= BUF1BUF2n;
            picture_q <= 8'h00;
            vpos_q    <= 8'h00;
        end else begin
            buf_q <= BUF1BUF2n;
            if (sample && !HC[2]) begin
                picture_q <= SR[15:8];
                vpos_q    <= SR[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_desc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || line_chg) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
            if (hit && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (count_q != '0) state_d = StReq;
            StReq:   if (rom.rom_ack) state_d = StDraw;
            StDraw:  if (pix_cnt_q == 3'd7) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (line_chg) begin
            state_d = StIdle;
        end
    end

    // Pixel i sits at bit offset 4*(7-i); hflip walks the row from the other end.
    always_comb begin
        rom.rom_req = (state_q == StReq);
        pop         = (state_q == StIdle) && (count_q != '0) && !line_chg;
        pix_sel     = cur_attr_q[ATTR_HFLIP_BIT] ? pix_cnt_q : ~pix_cnt_q;
        draw_pix    = data_q[{pix_sel, 2'b00} +: 4];
        wr_en       = (state_q == StDraw) && (draw_pix != TRANSPARENT) && !line_chg;
        wr_addr     = cur_hpos_q + {5'b00000, pix_cnt_q};
        wr_data     = {cur_attr_q[3:0], draw_pix};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q     <= 12'h000;
            cur_attr_q <= 5'h00;
            cur_hpos_q <= 8'h00;
            data_q     <= 32'h0;
            pix_cnt_q  <= 3'd0;
        end else begin
            if (pop) begin
                addr_q     <= {head.picture, head.row};
                cur_attr_q <= head.attr;
                cur_hpos_q <= head.hpos;
            end
            if ((state_q == StReq) && rom.rom_ack) begin
                data_q    <= rom.rom_data;
                pix_cnt_q <= 3'd0;
            end else if (state_q == StDraw) begin
                pix_cnt_q <= pix_cnt_q + 3'd1;
            end
        end
    end

    assign rom.rom_addr = addr_q;
    assign mo_ovf       = ovf_q;

    mo_linebuf_dp u_linebuf (
        .clk     (clk),
        .reset_n (reset_n),
        .sel     (BUF1BUF2n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (disp_x),
        .rd_data (disp_pix)
    );

endmodule

// File: tb/tb_mo_line_buffer.sv
// Self-checking bench for mo_line_buffer: scoreboard of expected display pixels plus ROM/FSM checks.
module tb_mo_line_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce2H;
    logic [8:0]  HC;
    logic [7:0]  VNEXT;
    logic        BUF1BUF2n;
    logic [15:0] SR;
    logic [7:0]  disp_x;
    logic [7:0]  disp_pix;
    logic        mo_ovf;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  model_mem [2][256];

    always #5 clk = ~clk;

    mo_line_buffer_if rom_if ();

    mo_line_buffer #(
        .NUM_OBJ (40),
        .OBJ_H   (16),
        .FIFO_D  (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce2H      (ce2H),
        .HC        (HC),
        .VNEXT     (VNEXT),
        .BUF1BUF2n (BUF1BUF2n),
        .SR        (SR),
        .rom       (rom_if),
        .disp_x    (disp_x),
        .disp_pix  (disp_pix),
        .mo_ovf    (mo_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Half A = 0, half B = 1; BUF1BUF2n=1 builds A and displays B.
    function automatic int build_half();
        return BUF1BUF2n ? 0 : 1;
    endfunction

    function automatic int disp_half();
        return BUF1BUF2n ? 1 : 0;
    endfunction

    task automatic paint(input logic [31:0] data, input logic [7:0] attr, input logic [7:0] hpos);
        int bh;
        bh = build_half();
        for (int i = 0; i < 8; i++) begin
            int src;
            logic [3:0] pix;
            src = attr[4] ? 7 - i : i;
            pix = 4'((data >> (28 - 4 * src)) & 32'hF);
            if (pix != 4'h0) model_mem[bh][(int'(hpos) + i) % 256] = {attr[3:0], pix};
        end
    endtask

    task automatic feed(input int idx, input logic [15:0] word);
        HC   = {7'(idx), 2'b11};
        SR   = word;
        ce2H = 1'b1;
        tick();
        ce2H = 1'b0;
    endtask

    task automatic feed_obj(input int slot, input logic [7:0] pic, input logic [7:0] vpos,
                            input logic [7:0] attr, input logic [7:0] hpos);
        feed(2 * slot, {pic, vpos});
        feed(2 * slot + 1, {attr, hpos});
    endtask

    task automatic wait_req(output bit seen);
        int n;
        n = 0;
        while (rom_if.rom_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        seen = (rom_if.rom_req === 1'b1);
    endtask

    task automatic serve(input string tag, input logic [11:0] exp_addr, input logic [31:0] data,
                         input logic [7:0] attr, input logic [7:0] hpos);
        bit seen;
        wait_req(seen);
        check_eq({tag, "_req"}, 32'(seen), 32'd1);
        if (seen) begin
            check_eq({tag, "_addr"}, 32'(rom_if.rom_addr), 32'(exp_addr));
            rom_if.rom_ack  = 1'b1;
            rom_if.rom_data = data;
            tick();
            rom_if.rom_ack  = 1'b0;
            rom_if.rom_data = 32'h0;
            paint(data, attr, hpos);
            repeat (10) tick();
        end
    endtask

    // The parked display address is read (and cleared) continuously in the new display half.
    task automatic toggle_buf();
        BUF1BUF2n = ~BUF1BUF2n;
        model_mem[disp_half()][disp_x] = 8'h00;
    endtask

    task automatic swap();
        toggle_buf();
        tick();
        tick();
    endtask

    task automatic sweep(input bit do_check);
        int dh;
        logic [7:0] exp;
        dh = disp_half();
        for (int k = 0; k < 256; k++) begin
            disp_x = 8'(k);
            exp_q.push_back(model_mem[dh][k]);
            model_mem[dh][k] = 8'h00;
            tick();
            exp = exp_q.pop_front();
            if (do_check) check_eq($sformatf("pix_x%02h", k), 32'(disp_pix), 32'(exp));
        end
    endtask

    task automatic count_reqs(input int cycles, output int reqs);
        reqs = 0;
        repeat (cycles) begin
            tick();
            if (rom_if.rom_req === 1'b1) reqs++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int reqs;

        reset_n         = 1'b0;
        ce2H            = 1'b0;
        HC              = 9'h000;
        VNEXT           = 8'h00;
        BUF1BUF2n       = 1'b1;
        SR              = 16'h0000;
        disp_x          = 8'h00;
        rom_if.rom_ack  = 1'b0;
        rom_if.rom_data = 32'h0;
        for (int h = 0; h < 2; h++) begin
            for (int a = 0; a < 256; a++) model_mem[h][a] = 8'h00;
        end
        repeat (3) tick();

        check_eq("rst_rom_req", 32'(rom_if.rom_req), 32'd0);
        check_eq("rst_rom_addr", 32'(rom_if.rom_addr), 32'd0);
        check_eq("rst_disp_pix", 32'(disp_pix), 32'd0);
        check_eq("rst_mo_ovf", 32'(mo_ovf), 32'd0);

        reset_n = 1'b1;
        tick();

        // Blank both halves through read-and-clear.
        sweep(1'b0);
        swap();
        sweep(1'b0);

        // Single hit, row 5.
        VNEXT = 8'h25;
        feed_obj(0, 8'h12, 8'h20, 8'h03, 8'h40);
        serve("single", 12'h125, 32'h1234_5678, 8'h03, 8'h40);
        swap();
        sweep(1'b1);

        // Opaque object then hflipped mostly-transparent object over it.
        feed_obj(0, 8'h12, 8'h20, 8'h05, 8'h60);
        feed_obj(1, 8'h34, 8'h25, 8'h13, 8'h60);
        serve("base", 12'h125, 32'h1234_5678, 8'h05, 8'h60);
        serve("flip", 12'h340, 32'h0000_0009, 8'h13, 8'h60);
        swap();
        sweep(1'b1);

        // Horizontal wrap at the right edge.
        feed_obj(0, 8'h56, 8'h24, 8'h07, 8'hFC);
        serve("hwrap", 12'h561, 32'h9ABC_DEF1, 8'h07, 8'hFC);
        swap();
        sweep(1'b1);

        // Overflow with ack held off.
        check_eq("ovf_pre", 32'(mo_ovf), 32'd0);
        for (int s = 0; s < 6; s++) begin
            feed_obj(s, 8'(8'h40 + s), 8'h20, 8'h01, 8'(16 * s));
        end
        check_eq("ovf_set", 32'(mo_ovf), 32'd1);
        check_eq("ovf_req_held", 32'(rom_if.rom_req), 32'd1);
        check_eq("ovf_addr_held", 32'(rom_if.rom_addr), 32'h405);
        swap();
        check_eq("ovf_clear", 32'(mo_ovf), 32'd0);
        check_eq("ovf_req_drop", 32'(rom_if.rom_req), 32'd0);
        count_reqs(6, reqs);
        check_eq("ovf_flushed", 32'(reqs), 32'd0);

        // Abort mid-request; the late ack must be ignored.
        feed_obj(0, 8'h77, 8'h25, 8'h02, 8'h10);
        wait_req(seen);
        check_eq("abort_req", 32'(seen), 32'd1);
        check_eq("abort_addr", 32'(rom_if.rom_addr), 32'h770);
        toggle_buf();
        tick();
        check_eq("abort_req_drop", 32'(rom_if.rom_req), 32'd0);
        tick();
        rom_if.rom_ack  = 1'b1;
        rom_if.rom_data = 32'hFFFF_FFFF;
        tick();
        rom_if.rom_ack  = 1'b0;
        rom_if.rom_data = 32'h0;
        count_reqs(12, reqs);
        check_eq("abort_idle", 32'(reqs), 32'd0);
        swap();
        sweep(1'b1);

        // Vertical wrap hit at row 15, then a miss one line later.
        VNEXT = 8'h07;
        feed_obj(0, 8'h9A, 8'hF8, 8'h04, 8'h20);
        serve("vwrap", 12'h9AF, 32'h1111_1111, 8'h04, 8'h20);
        VNEXT = 8'h08;
        feed_obj(0, 8'h9A, 8'hF8, 8'h04, 8'h20);
        count_reqs(12, reqs);
        check_eq("vmiss", 32'(reqs), 32'd0);
        swap();
        sweep(1'b1);

        // Reset while a request is outstanding.
        VNEXT = 8'h25;
        feed_obj(0, 8'h12, 8'h20, 8'h03, 8'h40);
        wait_req(seen);
        check_eq("rstmid_req", 32'(seen), 32'd1);
        reset_n = 1'b0;
        tick();
        check_eq("rstmid_req_drop", 32'(rom_if.rom_req), 32'd0);
        check_eq("rstmid_addr", 32'(rom_if.rom_addr), 32'd0);
        reset_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
